lifo_rr_arbiter: RTL
====================

Name: lifo_rr_arbiter

Overview:
- Shares one LIFO storage array (DEPTH x DATA_W) among NUM_REQ requesters. Each requester can push or pop.
- Round-robin arbitration grants at most one operation per cycle.
- Each grant returns a registered response tagged with the requester ID.
- Provides a multi-cycle flush sequence. Sits between requester blocks and the shared LIFO queue storage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, data width
- DEPTH, 16, LIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_op  in  NUM_REQ  per-requester op: 1=push, 0=pop
- req_data  in  NUM_REQ*DATA_W  push data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant, combinational, same cycle as the accepted request
- flush  in  1  start flush (pulse or level)
- rsp_valid  out  1  response valid
- rsp_id  out  $clog2(NUM_REQ)  granted requester index
- rsp_data  out  DATA_W  popped value (pop) or written value (push); 0 on error
- rsp_err  out  1  push while full or pop while empty
- top_value  out  DATA_W  current top entry; 0 when empty
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0
- busy  out  1  high while in FLUSH

Behaviour:
- Reset (synchronous, reset high at a clk edge):
  - state=IDLE, rr_ptr=0, count=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, top_value=0, busy=0.
  - Storage contents are don't-care.
  - reset has priority over everything, including reset during FLUSH or mid-grant; the granted op is discarded.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when flush=1 and count>0.
  - flush=1 with count==0 stays in IDLE with no effect.
  - FLUSH decrements count by 1 per cycle and zeroes the vacated entry.
  - FLUSH -> IDLE on the cycle count reaches 0. A DEPTH=16 full flush takes 16 cycles.
  - busy=1 exactly while state==FLUSH.
  - req_ready=0 throughout FLUSH; requesters hold req_valid.
- Arbitration (IDLE only):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready is one-hot for the winner, all zero if no request.
  - On a grant to i: rr_ptr <= (i+1) mod NUM_REQ. Without a grant rr_ptr holds.
  - flush asserted in IDLE in the same cycle as requests: flush wins, no grant that cycle.
- Push grant at cycle T:
  - If !full: mem[count]<=data, count+1.
  - If full: no storage change, rsp_err=1.
- Pop grant at cycle T:
  - If !empty: rsp_data<=mem[count-1], count-1.
  - If empty: rsp_err=1, rsp_data=0.
- Response:
  - rsp_valid=1 for exactly one cycle at T+1, with rsp_id=i.
  - rsp_valid=0 in cycles without a grant. rsp_id, rsp_data and rsp_err hold their last values; consumers qualify them with rsp_valid.
- top_value and flags:
  - top_value is registered and reflects the post-operation stack at T+1: mem[count-1] or 0.
  - full and empty are decoded from the registered count.
- Back-to-back grants are sustained at one per cycle. Count never exceeds DEPTH or underflows.

Test Plan:
- Reset, then req_valid=4'b0001, op=push, data 8'hA5 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=A5, count=1, top_value=A5, empty=0.
- All four requesters push continuously from empty (data 10,11,12,13) -> grants 0,1,2,3,0,... one per cycle; after 4 cycles count=4, top_value=13.
- Fill to 16 entries, then push 8'h77 -> rsp_err=1, count stays 16, full=1, top unchanged. Then pop -> rsp_data equals the last pushed value, count=15.
- Pop on empty from requester 2 -> rsp_valid=1, rsp_id=2, rsp_err=1, rsp_data=0, count=0.
- count=5, assert flush while requesters 1 and 3 are valid -> no grant that cycle; busy=1 for 5 cycles with count 5->0, req_ready=0; then IDLE and grant to the rr_ptr-ordered requester.
- Reset asserted during FLUSH at count=3 -> next cycle busy=0, count=0, rsp_valid=0, rr_ptr=0 (requester 0 granted first afterwards).

Source files
------------

// File: rtl/lifo_rr_arbiter.sv
// -----------------------------------------------------------------------------
// lifo_rr_arbiter
//
// Purpose:
//   Shares one LIFO storage array (DEPTH x DATA_W) among NUM_REQ requesters.
//   A round-robin arbiter grants at most one push or pop per cycle. Every grant
//   produces a registered response one cycle later, tagged with the requester
//   index. A multi-cycle flush empties the stack one entry per cycle, zeroing
//   each vacated entry.
//
// Handshake:
//   A requester asserts req_valid[i] (with req_op[i] / req_data slice) and
//   holds it until it sees req_ready[i] high in the same cycle. req_ready is
//   combinational and one-hot. The operation is accepted on the rising clock
//   edge where req_valid[i] && req_ready[i]. The response for that operation
//   appears as a single-cycle rsp_valid pulse on the following cycle. There is
//   no backpressure on the response side.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NUM_REQ]         per-requester request
//   req_op     in   [NUM_REQ]         1 = push, 0 = pop
//   req_data   in   [NUM_REQ*DATA_W]  push data, requester i at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         one-hot grant, same cycle as acceptance
//   flush      in   start flush (pulse or level)
//   rsp_valid  out  single-cycle response strobe
//   rsp_id     out  granted requester index
//   rsp_data   out  popped / written value, 0 on error
//   rsp_err    out  push while full or pop while empty
//   top_value  out  registered top-of-stack, 0 when empty
//   count      out  occupancy
//   full       out  count == DEPTH
//   empty      out  count == 0
//   busy       out  high while the FSM is in FLUSH (mirrors the FSM state)
// -----------------------------------------------------------------------------
module lifo_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_op,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         flush,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [DATA_W-1:0]            rsp_data,
  output logic                         rsp_err,
  output logic [DATA_W-1:0]            top_value,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic                         busy
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       rr_next;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [CNT_W-1:0]      count_next;
  logic [DATA_W-1:0]     top_next;
  logic                  rsp_valid_next;
  logic [ID_W-1:0]       rsp_id_next;
  logic [DATA_W-1:0]     rsp_data_next;
  logic                  rsp_err_next;

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;

  // ---------------------------------------------------------------------------
  // Flags and derived addresses
  // ---------------------------------------------------------------------------
  logic                  flush_start;
  logic                  grant_found;
  logic                  grant_en;
  logic [ID_W-1:0]       grant_id;
  logic [ID_W-1:0]       cand_id;
  logic                  sel_op;
  logic [DATA_W-1:0]     sel_data;
  logic [ADDR_W-1:0]     push_addr;
  logic [ADDR_W-1:0]     top_addr;
  logic [ADDR_W-1:0]     below_addr;
  logic [DATA_W-1:0]     below_value;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state == FLUSH);

  // push_addr is only used when not full, so count < DEPTH fits in ADDR_W.
  assign push_addr  = ADDR_W'(count);
  assign top_addr   = ADDR_W'(count - CNT_W'(1));
  assign below_addr = ADDR_W'(count - CNT_W'(2));

  // Value that becomes the new top after removing one entry; 0 when the
  // removal leaves the stack empty.
  assign below_value = (count > CNT_W'(1)) ? mem[below_addr] : '0;

  // A flush request only takes effect when there is something to flush; with
  // an empty stack it is ignored and normal arbitration proceeds.
  assign flush_start = flush && !empty;

  // ---------------------------------------------------------------------------
  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_id     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_id = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

  // Grants only in IDLE, and a flush that actually starts suppresses them.
  assign grant_en = (state == IDLE) && !flush_start && grant_found;

  always_comb begin
    req_ready = '0;
    if (grant_en) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Operation and data of the winning requester.
  always_comb begin
    sel_op   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_op   = req_op[i];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    count_next     = count;
    top_next       = top_value;
    rsp_valid_next = 1'b0;
    rsp_id_next    = rsp_id;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;
    mem_we         = 1'b0;
    mem_waddr      = '0;
    mem_wdata      = '0;

    unique case (state)
      IDLE: begin
        if (flush_start) begin
          state_next = FLUSH;
        end else if (grant_found) begin
          rsp_valid_next = 1'b1;
          rsp_id_next    = grant_id;
          if (sel_op) begin
            if (!full) begin
              mem_we        = 1'b1;
              mem_waddr     = push_addr;
              mem_wdata     = sel_data;
              count_next    = count + 1'b1;
              top_next      = sel_data;
              rsp_data_next = sel_data;
              rsp_err_next  = 1'b0;
            end else begin
              rsp_data_next = '0;
              rsp_err_next  = 1'b1;
            end
          end else begin
            if (!empty) begin
              count_next    = count - 1'b1;
              top_next      = below_value;
              rsp_data_next = mem[top_addr];
              rsp_err_next  = 1'b0;
            end else begin
              rsp_data_next = '0;
              rsp_err_next  = 1'b1;
            end
          end
        end
      end

      FLUSH: begin
        if (empty) begin
          // Not reachable in normal operation; recover rather than underflow.
          state_next = IDLE;
        end else begin
          mem_we     = 1'b1;
          mem_waddr  = top_addr;
          mem_wdata  = '0;
          count_next = count - 1'b1;
          top_next   = below_value;
          if (count == CNT_W'(1)) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      count     <= '0;
      top_value <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant_en) begin
        rr_ptr <= rr_next;
      end
      count     <= count_next;
      top_value <= top_next;
      rsp_valid <= rsp_valid_next;
      rsp_id    <= rsp_id_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
    end
  end

  // Storage has no reset; a write coinciding with reset is dropped so the
  // discarded operation leaves no trace.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready));

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(DEPTH));

  a_no_grant_in_flush: assert property (@(posedge clk) disable iff (reset)
    busy |-> (req_ready == '0));

endmodule
